// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter
// Round-robin arbiter that shares a bank of SR flip-flops between several
// requesters. Each granted command becomes one single-cycle, one-hot set or
// clear pulse. A mandatory RECOVER cycle after every pulse guarantees the
// flop bank sees an idle input between consecutive commands.

module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*AW-1:0]   addr,
    output logic [NREQ-1:0]      gnt,
    output logic [NFLAG-1:0]     s,
    output logic [NFLAG-1:0]     r,
    output logic                 busy,
    output logic                 err
);

    // Width of the round-robin pointer and of a requester index.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RECOVER
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   cur_idx;
    logic [PW-1:0]   ptr_next;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic            win_op;
    logic [AW-1:0]   win_addr;

    logic [NREQ-1:0]  nxt_gnt;
    logic [NFLAG-1:0] nxt_s;
    logic [NFLAG-1:0] nxt_r;
    logic             nxt_err;

    // Round-robin search: the first active request at or after ptr, wrapping at NREQ.
    always_comb begin
        logic [PW:0]   cand_w;
        logic [PW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand_w    = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_w = {1'b0, ptr} + (PW+1)'(k);
            if (cand_w >= (PW+1)'(NREQ)) begin
                cand_w = cand_w - (PW+1)'(NREQ);
            end
            cand = cand_w[PW-1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Fetch the winner's command and turn it into the grant/set/clear/err pulses
    // that will be registered when the ISSUE cycle starts.
    always_comb begin
        win_op   = 1'b0;
        win_addr = '0;
        nxt_gnt  = '0;
        nxt_s    = '0;
        nxt_r    = '0;
        nxt_err  = 1'b0;
        for (int g = 0; g < NREQ; g++) begin
            if (PW'(g) == win_idx) begin
                win_op     = op[g];
                win_addr   = addr[g*AW +: AW];
                nxt_gnt[g] = 1'b1;
            end
        end
        // An address past the end of the bank is still granted, but only
        // raises err; no flop may be touched.
        if (int'(win_addr) >= NFLAG) begin
            nxt_err = 1'b1;
        end else begin
            for (int f = 0; f < NFLAG; f++) begin
                if (int'(win_addr) == f) begin
                    if (win_op) begin
                        nxt_s[f] = 1'b1;
                    end else begin
                        nxt_r[f] = 1'b1;
                    end
                end
            end
        end
    end

    // Pointer value after serving cur_idx: the requester just past it, wrapping.
    always_comb begin
        if (cur_idx == PW'(NREQ-1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = cur_idx + PW'(1);
        end
    end

    // Control FSM with registered outputs; reset clears every pulse at once so
    // an interrupted command never reaches the flops and is not replayed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            cur_idx <= '0;
            gnt     <= '0;
            s       <= '0;
            r       <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE, RECOVER: begin
                    if (win_found) begin
                        state   <= ISSUE;
                        cur_idx <= win_idx;
                        gnt     <= nxt_gnt;
                        s       <= nxt_s;
                        r       <= nxt_r;
                        err     <= nxt_err;
                        busy    <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        gnt     <= '0;
                        s       <= '0;
                        r       <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ISSUE: begin
                    state <= RECOVER;
                    ptr   <= ptr_next;
                    gnt   <= '0;
                    s     <= '0;
                    r     <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    s     <= '0;
                    r     <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // The flop bank must never see set and clear together, nor two flops touched at once.
    a_no_sr_overlap: assert property (@(posedge clk) disable iff (reset) (s & r) == '0);
    a_onehot_sr:     assert property (@(posedge clk) disable iff (reset) $onehot0(s | r));
    a_onehot_gnt:    assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter
// Drives two arbiters (8-flag and 6-flag banks) from the same requesters,
// keeps a transaction-level reference model and an attached SR flop bank,
// and checks outputs every cycle plus hand-computed directed expectations.

module tb_sr_flag_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int NF6  = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [NREQ-1:0]    req  = '0;
    logic [NREQ-1:0]    op   = '0;
    logic [NREQ*AW-1:0] addr = '0;

    logic [NREQ-1:0] gnt8, gnt6;
    logic [7:0]      s8, r8;
    logic [5:0]      s6, r6;
    logic            busy8, busy6, err8, err6;

    int total = 0;
    int bad   = 0;

    // Flop bank hanging off the 8-flag arbiter.
    logic [7:0] q8 = '0;

    // Reference model state.
    logic [NREQ-1:0] exp_gnt  = '0;
    logic [7:0]      exp_s8   = '0;
    logic [7:0]      exp_r8   = '0;
    logic [7:0]      exp_q8   = '0;
    logic [5:0]      exp_s6   = '0;
    logic [5:0]      exp_r6   = '0;
    logic            exp_err6 = 1'b0;
    logic            exp_busy = 1'b0;
    int              mptr     = 0;
    bit              cmp_on   = 1'b0;

    // Grants observed by the serve task.
    int         g_idx[$];
    int         g_cyc[$];
    logic [7:0] g_s[$];
    logic [7:0] g_r[$];

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(8), .AW(AW)) dut8 (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr),
        .gnt(gnt8), .s(s8), .r(r8), .busy(busy8), .err(err8)
    );

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NF6), .AW(AW)) dut6 (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr),
        .gnt(gnt6), .s(s6), .r(r6), .busy(busy6), .err(err6)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // SR flop bank: set on s, clear on r, captured at the rising edge.
    always @(posedge clk) begin
        q8 <= (q8 & ~r8) | s8;
    end

    // Reference model: a new command may start on any edge whose preceding
    // cycle carried no grant; the winner is the first requester at or after
    // the pointer; busy covers the grant cycle and the cycle after it.
    always @(posedge clk or posedge reset) begin : model_b
        int w;
        int a;
        int idx;
        logic had_grant;
        logic [NREQ-1:0] rs;
        logic [NREQ-1:0] os;
        logic [NREQ*AW-1:0] ash;
        if (reset) begin
            exp_gnt  = '0;
            exp_s8   = '0;
            exp_r8   = '0;
            exp_s6   = '0;
            exp_r6   = '0;
            exp_err6 = 1'b0;
            exp_busy = 1'b0;
            mptr     = 0;
        end else begin
            exp_q8    = (exp_q8 & ~exp_r8) | exp_s8;
            had_grant = (exp_gnt != '0);
            exp_gnt   = '0;
            exp_s8    = '0;
            exp_r8    = '0;
            exp_s6    = '0;
            exp_r6    = '0;
            exp_err6  = 1'b0;
            w         = -1;
            if (!had_grant) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (mptr + k) % NREQ;
                    rs  = req >> idx;
                    if (w < 0 && rs[0]) w = idx;
                end
            end
            if (w >= 0) begin
                ash = addr >> (w * AW);
                a   = int'(ash[AW-1:0]);
                os  = op >> w;
                exp_gnt = NREQ'(1) << w;
                if (os[0]) exp_s8 = 8'(1) << a;
                else       exp_r8 = 8'(1) << a;
                if (a < NF6) begin
                    if (os[0]) exp_s6 = 6'(1) << a;
                    else       exp_r6 = 6'(1) << a;
                end else begin
                    exp_err6 = 1'b1;
                end
                mptr     = (w + 1) % NREQ;
                exp_busy = 1'b1;
            end else begin
                exp_busy = had_grant;
            end
        end
    end

    // One comparison point, counted and reported on failure.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present a new set of requests half a cycle away from the active edge.
    task automatic applyStimulus(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] o,
                                 input logic [NREQ*AW-1:0] a);
        @(negedge clk);
        req  = rq;
        op   = o;
        addr = a;
    endtask

    // Behave like the requesters: drop req on grant, log each grant.
    task automatic serve(input int budget);
        int n;
        logic [NREQ-1:0] gs;
        n = 0;
        g_idx.delete(); g_cyc.delete(); g_s.delete(); g_r.delete();
        while (req != '0 && n < budget) begin
            @(negedge clk);
            n++;
            if ((gnt8 & req) != '0) begin
                for (int b = 0; b < NREQ; b++) begin
                    gs = gnt8 >> b;
                    if (gs[0]) g_idx.push_back(b);
                end
                g_cyc.push_back(n);
                g_s.push_back(s8);
                g_r.push_back(r8);
                req = req & ~gnt8;
            end
        end
        if (req != '0) begin
            checkOutput("serve_timeout", 32'(req), 32'd0);
            req = '0;
        end
    endtask

    // Per-cycle comparison of both arbiters against the model.
    always @(posedge clk) begin
        #2;
        if (cmp_on) begin
            checkOutput("gnt8",  32'(gnt8),  32'(exp_gnt));
            checkOutput("gnt6",  32'(gnt6),  32'(exp_gnt));
            checkOutput("s8",    32'(s8),    32'(exp_s8));
            checkOutput("r8",    32'(r8),    32'(exp_r8));
            checkOutput("s6",    32'(s6),    32'(exp_s6));
            checkOutput("r6",    32'(r6),    32'(exp_r6));
            checkOutput("err8",  32'(err8),  32'd0);
            checkOutput("err6",  32'(err6),  32'(exp_err6));
            checkOutput("busy8", 32'(busy8), 32'(exp_busy));
            checkOutput("busy6", 32'(busy6), 32'(exp_busy));
            checkOutput("q8",    32'(q8),    32'(exp_q8));
            checkOutput("s_and_r",    32'(s8 & r8), 32'd0);
            checkOutput("onehot0_sr", 32'($onehot0(s8 | r8)), 32'd1);
        end
    end

    // Give up if the run wanders off.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        // Reset held for two rising edges.
        repeat (2) @(negedge clk);
        cmp_on = 1'b1;
        reset  = 1'b0;
        checkOutput("rst_gnt",  32'(gnt8),  32'd0);
        checkOutput("rst_s",    32'(s8),    32'd0);
        checkOutput("rst_r",    32'(r8),    32'd0);
        checkOutput("rst_busy", 32'(busy8), 32'd0);
        checkOutput("rst_err",  32'(err6),  32'd0);
        checkOutput("rst_q",    32'(q8),    32'd0);

        // Single set of flag 3, then clear it.
        applyStimulus(4'b0001, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd3});
        @(negedge clk);
        checkOutput("set_gnt",  32'(gnt8),  32'h1);
        checkOutput("set_s",    32'(s8),    32'h08);
        checkOutput("set_r",    32'(r8),    32'h00);
        checkOutput("set_busy", 32'(busy8), 32'd1);
        req = '0;
        @(negedge clk);
        checkOutput("set_q",       32'(q8),    32'h08);
        checkOutput("recover_gnt", 32'(gnt8),  32'h0);
        checkOutput("recover_busy",32'(busy8), 32'd1);
        @(negedge clk);
        checkOutput("idle_busy",   32'(busy8), 32'd0);
        applyStimulus(4'b0001, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd3});
        @(negedge clk);
        checkOutput("clr_r", 32'(r8), 32'h08);
        checkOutput("clr_s", 32'(s8), 32'h00);
        req = '0;
        @(negedge clk);
        checkOutput("clr_q", 32'(q8), 32'h00);

        // Fresh reset so the pointer starts at 0, then all four at once.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'b1111, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0});
        serve(20);
        checkOutput("all4_count", 32'(g_idx.size()), 32'd4);
        for (int i = 0; i < g_idx.size() && i < 4; i++) begin
            checkOutput("all4_order", 32'(g_idx[i]), 32'(i));
            checkOutput("all4_s",     32'(g_s[i]),   32'(8'(1) << i));
            if (i > 0) checkOutput("all4_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd2);
        end
        @(negedge clk);
        checkOutput("all4_q", 32'(q8), 32'h0F);

        // Wrap: requesters 3 and 1 together, pointer back at 0 -> 1 first.
        applyStimulus(4'b1010, 4'b1000, {3'd6, 3'd0, 3'd1, 3'd0});
        serve(20);
        checkOutput("wrap_count", 32'(g_idx.size()), 32'd2);
        if (g_idx.size() == 2) begin
            checkOutput("wrap_first",  32'(g_idx[0]), 32'd1);
            checkOutput("wrap_r1",     32'(g_r[0]),   32'h02);
            checkOutput("wrap_second", 32'(g_idx[1]), 32'd3);
            checkOutput("wrap_s3",     32'(g_s[1]),   32'h40);
        end
        @(negedge clk);
        checkOutput("wrap_q", 32'(q8), 32'h4D);

        // Address 7 against the 6-flag bank.
        applyStimulus(4'b0100, 4'b0100, {3'd0, 3'd7, 3'd0, 3'd0});
        @(negedge clk);
        checkOutput("oor_gnt6", 32'(gnt6), 32'h4);
        checkOutput("oor_err6", 32'(err6), 32'd1);
        checkOutput("oor_s6",   32'(s6),   32'h00);
        checkOutput("oor_r6",   32'(r6),   32'h00);
        checkOutput("oor_s8",   32'(s8),   32'h80);
        checkOutput("oor_err8", 32'(err8), 32'd0);
        req = '0;
        @(negedge clk);
        // Last valid flag of the 6-flag bank.
        applyStimulus(4'b0001, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd5});
        @(negedge clk);
        checkOutput("edge5_s6",   32'(s6),   32'h20);
        checkOutput("edge5_err6", 32'(err6), 32'd0);
        req = '0;
        @(negedge clk);
        // First invalid flag of the 6-flag bank.
        applyStimulus(4'b0010, 4'b0010, {3'd0, 3'd0, 3'd6, 3'd0});
        @(negedge clk);
        checkOutput("edge6_err6", 32'(err6), 32'd1);
        checkOutput("edge6_s6",   32'(s6),   32'h00);
        checkOutput("edge6_s8",   32'(s8),   32'h40);
        req = '0;
        @(negedge clk);
        checkOutput("oor_q", 32'(q8), 32'hED);

        // Reset in the middle of an ISSUE cycle. Pointer is 2 here, so
        // requester 2 wins first; after reset the pointer is 0 and 1 wins.
        applyStimulus(4'b0110, 4'b0010, {3'd0, 3'd0, 3'd4, 3'd0});
        @(negedge clk);
        checkOutput("mid_gnt_before", 32'(gnt8), 32'h4);
        checkOutput("mid_r_before",   32'(r8),   32'h01);
        reset = 1'b1;
        #1;
        checkOutput("mid_gnt",  32'(gnt8),  32'h0);
        checkOutput("mid_s",    32'(s8),    32'h00);
        checkOutput("mid_r",    32'(r8),    32'h00);
        checkOutput("mid_busy", 32'(busy8), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid_q", 32'(q8), 32'hED);
        serve(20);
        checkOutput("mid_count", 32'(g_idx.size()), 32'd2);
        if (g_idx.size() == 2) begin
            checkOutput("mid_first",  32'(g_idx[0]), 32'd1);
            checkOutput("mid_s1",     32'(g_s[0]),   32'h10);
            checkOutput("mid_second", 32'(g_idx[1]), 32'd2);
            checkOutput("mid_r2",     32'(g_r[1]),   32'h01);
        end
        @(negedge clk);
        checkOutput("mid_q_after", 32'(q8), 32'hFC);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
